// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, instr} buffer between memory responses and decode.
// Head entry is held in output registers; an empty buffer presents NOP at pc 0.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [ADDR_WIDTH-1:0]  i_push_pc,
  input  logic [INSTR_WIDTH-1:0] i_push_instr,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [CNT_W-1:0]       o_count
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;

  logic [ENTRY_W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;

  logic                   w_do_push;
  logic                   w_do_pop;
  logic                   w_head_is_new;
  logic [PTR_W-1:0]       w_rd_ptr_next;
  logic [CNT_W-1:0]       w_count_next;
  logic [ENTRY_W-1:0]     w_head_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_push = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && r_valid && !i_flush;

  // The new entry becomes the head when it lands in an otherwise empty buffer.
  always_comb begin
    w_rd_ptr_next = w_do_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_next  = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    w_head_is_new = w_do_push && (r_count == CNT_W'(w_do_pop));
    w_head_next   = w_head_is_new ? {i_push_pc, i_push_instr} : r_mem[w_rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= {i_push_pc, i_push_instr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_instr  <= INSTR_WIDTH'(NOP_INSTR);
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_instr  <= INSTR_WIDTH'(NOP_INSTR);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      if (w_count_next != '0) begin
        {r_pc, r_instr} <= w_head_next;
      end else begin
        r_pc    <= '0;
        r_instr <= INSTR_WIDTH'(NOP_INSTR);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, request credit tracking, redirect/flush handling.
// Responses still in flight at a redirect are counted as stale and dropped on arrival.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          DEPTH       = 4,
  localparam int unsigned         CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam logic [ADDR_WIDTH-1:0] BOOT_PC   = RESET_PC & ~ADDR_WIDTH'(3);
  localparam logic [CNT_W:0]        REQ_LIMIT = (CNT_W + 1)'(DEPTH);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_push_pc;
  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      r_stale;

  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic [ADDR_WIDTH-1:0] w_pc_step;
  logic [CNT_W-1:0]      w_occ;
  logic [CNT_W-1:0]      w_inflight_next;
  logic [CNT_W-1:0]      w_stale_dec;
  logic [CNT_W:0]        w_committed;
  logic                  w_req_accept;
  logic                  w_rsp_eff;
  logic                  w_push;
  logic                  w_pop;

  assign w_pc_step     = ADDR_WIDTH'(PC_STEP);
  assign w_redirect_pc = redirect_pc & ~ADDR_WIDTH'(3);

  // Credit excludes a same-cycle pop, so issue depends on registered state only.
  assign w_committed    = {1'b0, r_inflight} + {1'b0, w_occ};
  assign imem_req_valid = (r_state == RUN) && (w_committed < REQ_LIMIT);
  assign imem_req_addr  = r_pc;

  assign w_req_accept    = imem_req_valid && imem_req_ready;
  assign w_rsp_eff       = imem_rsp_valid && (r_inflight != '0);
  assign w_push          = w_rsp_eff && (r_stale == '0) && !redirect_valid;
  assign w_pop           = instr_valid && instr_ready;
  assign w_inflight_next = r_inflight + CNT_W'(w_req_accept) - CNT_W'(w_rsp_eff);
  assign w_stale_dec     = (w_rsp_eff && (r_stale != '0)) ? r_stale - CNT_W'(1) : r_stale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= BOOT_PC;
      r_push_pc  <= BOOT_PC;
      r_inflight <= '0;
      r_stale    <= '0;
    end else begin
      r_inflight <= w_inflight_next;
      if (redirect_valid) begin
        r_pc      <= w_redirect_pc;
        r_push_pc <= w_redirect_pc;
        r_stale   <= w_inflight_next;
        r_state   <= ((r_state == FLUSH) || (w_inflight_next != '0)) ? FLUSH : RUN;
      end else begin
        if (w_req_accept) begin
          r_pc <= r_pc + w_pc_step;
        end
        if (w_push) begin
          r_push_pc <= r_push_pc + w_pc_step;
        end
        r_stale <= w_stale_dec;
        case (r_state)
          BOOT:    r_state <= RUN;
          RUN:     r_state <= RUN;
          FLUSH:   if (w_stale_dec == '0) r_state <= RUN;
          default: r_state <= BOOT;
        endcase
      end
    end
  end

  fetch_fifo #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_pc   (r_push_pc),
    .i_push_instr(imem_rsp_data),
    .i_pop       (w_pop),
    .o_valid     (instr_valid),
    .o_pc        (instr_pc),
    .o_instr     (instr),
    .o_count     (w_occ)
  );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Holds the program counter and issues word requests to instruction memory over a valid/ready channel. Buffers in-order responses in a small FIFO and presents each instruction with its PC to decode over a valid/ready handshake. Handles control-flow redirects by flushing the buffer and discarding stale in-flight responses.

## Interface
- `INSTR_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, 32: PC / memory address width.
- `RESET_PC`, 0: first fetch address after reset; low 2 bits must be 0.
- `DEPTH`, 4: buffer entries and maximum in-flight requests; minimum 2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req_valid` out 1: a fetch request is offered.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out ADDR_WIDTH: word-aligned fetch address.
- `imem_rsp_valid` in 1: response data is valid; responses arrive in request order with latency ≥1 cycle.
- `imem_rsp_data` in INSTR_WIDTH: fetched word.
- `redirect_valid` in 1: a one-cycle pulse that restarts fetch.
- `redirect_pc` in ADDR_WIDTH: redirect target; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: an instruction is presented to decode.
- `instr_ready` in 1: decode consumes the instruction.
- `instr` out INSTR_WIDTH: instruction word; NOP `32'h0000_0013` when the buffer is empty.
- `instr_pc` out ADDR_WIDTH: PC of `instr`.

## Operation
State machine states: BOOT, RUN, FLUSH.
- **Reset:**
  - State goes to BOOT; PC = `RESET_PC`.
  - Buffer is emptied; in-flight count and stale count are set to 0.
  - Outputs: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `instr_valid`=0, `instr`=NOP, `instr_pc`=0.
- **BOOT:**
  - Lasts one cycle after reset deassertion, with no request issued.
  - Then moves to RUN.
- **RUN:**
  - `imem_req_valid`=1 when in-flight count + buffer occupancy < DEPTH. A same-cycle pop is not credited.
  - On accept (`imem_req_valid && imem_req_ready`): PC += 4, wrapping modulo 2^ADDR_WIDTH, and in-flight count +1.
  - `imem_req_addr`=PC. Address and valid are held stable while not accepted.
- **Response:**
  - Each `imem_rsp_valid` decrements the in-flight count.
  - If the stale count is nonzero, the stale count is decremented and the data is dropped. Otherwise the data is pushed into the buffer with its PC. PCs are tracked by a second PC pointer advanced on each push.
  - `imem_rsp_valid` while the in-flight count is 0 is ignored.
- **Decode side:**
  - `instr_valid` = buffer not empty.
  - Pop on `instr_valid && instr_ready`.
  - `instr` and `instr_pc` are held stable while valid and not ready.
- **Redirect:**
  - PC and the push PC pointer are set to `redirect_pc & ~3`.
  - The buffer is flushed.
  - Stale count = in-flight count, including a request accepted in the same cycle and excluding a response in the same cycle, which is itself dropped.
  - Next state is FLUSH if the resulting stale count > 0, else RUN.
- **FLUSH:**
  - `imem_req_valid`=0, the only permitted withdrawal of an unaccepted request.
  - Move to RUN the cycle after the stale count reaches 0.
  - A redirect while in FLUSH updates the PC and stays in FLUSH.
- **Simultaneous events:**
  - A decode handshake in the same cycle as a redirect completes normally, then the buffer is flushed.
  - A redirect in BOOT is taken and goes to RUN.
  - Push and pop in the same cycle are both honoured.

## Timing
- Response to `instr_valid` latency is 1 cycle; the buffer output is registered with no bypass.
- Reset deassertion to first `imem_req_valid` is 2 cycles (BOOT, then RUN).
- Redirect with nothing in flight: the request at the target is issued in the next cycle.
- Full throughput, one instruction per cycle, with 1-cycle memory latency requires DEPTH ≥ 3.
- `rst_n` assertion mid-operation clears all state asynchronously; responses arriving after reset are ignored by the in-flight=0 rule.
- No combinational path from `instr_ready` or `imem_rsp_valid` to `imem_req_valid`.

## Structure
- Package `fetch_pkg` holds:
  - the `fetch_state_t` enum {BOOT, RUN, FLUSH};
  - `NOP_INSTR` = `32'h0000_0013`;
  - `PC_STEP` = 4.
- Sub-module `fetch_fifo`: a synchronous FIFO of {pc, instr} entries with depth DEPTH, registered outputs, a flush input and an occupancy output.
- The counters and state machine live in `instr_fetch`.

## Test plan
- **Reset and boot:** reset, then release with memory ready and 1-cycle latency. Required: req addrs 0x0, 0x4, 0x8…; `instr_pc` 0x0 first, appearing 2 cycles after the first accept. All outputs are at reset values during reset.
- **Backpressure:** hold `instr_ready`=0 with DEPTH=4. Required: exactly 4 requests issued, then `imem_req_valid`=0; `instr`/`instr_pc` stable. Releasing `instr_ready` resumes issue.
- **Redirect with stale responses:** redirect to 0x103 with 2 requests in flight. Required: both responses dropped; the next request is at 0x100; the first delivered `instr_pc`=0x100; no 0x8/0xC instructions reach decode.
- **Simultaneous events:** redirect in the same cycle as a response and a decode handshake. Required: the response is dropped, the handshake completes, and the buffer is empty next cycle.
- **Memory stall and wrap:** `imem_req_ready`=0 for 5 cycles with PC=0xFFFF_FFFC. Required: addr held stable; after accept the PC wraps to 0x0.
- **Reset mid-operation:** assert `rst_n` with 3 in flight, then release; inject late responses. Required: late responses ignored; fetch restarts at `RESET_PC`.
